// File: rtl/ltc2308_ctrl.sv
// LTC2308 SPI master: issues CONVST, shifts the next 6-bit config on SDI while reading the 12-bit
// SDO result, and tags each result with the channel that produced it (one-frame pipeline).
module ltc2308_ctrl #(
  parameter int CONVST_CYC = 1,
  parameter int SCK_HALF   = 1,
  parameter int CONV_CYC   = 80,
  parameter int CYC_CYC    = 110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  cfg_ch,
  input  logic        cfg_sgl,
  input  logic        cfg_uni,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic [11:0] data,
  output logic [2:0]  data_ch,
  output logic        data_valid,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] T_CONVST    = 8'(CONVST_CYC);
  localparam logic [7:0] T_CONV_LAST = 8'(CONV_CYC - 1);
  localparam logic [7:0] T_CYC_LAST  = 8'(CYC_CYC - 1);
  localparam logic [7:0] HALF_LAST   = 8'(SCK_HALF - 1);

  if (CONVST_CYC < 1 || CONV_CYC <= CONVST_CYC) begin : g_chk_conv
    $error("ltc2308_ctrl: need 1 <= CONVST_CYC < CONV_CYC");
  end
  if (SCK_HALF < 1 || SCK_HALF > 256) begin : g_chk_sck
    $error("ltc2308_ctrl: SCK_HALF must be 1..256");
  end
  if (CYC_CYC < CONV_CYC + 24 * SCK_HALF + 1 || CYC_CYC > 256) begin : g_chk_cyc
    $error("ltc2308_ctrl: need CONV_CYC + 24*SCK_HALF + 1 <= CYC_CYC <= 256");
  end

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_t, w_t_nxt;
  logic [7:0]  r_hcnt, w_hcnt_nxt;
  logic [4:0]  r_half, w_half_nxt;
  logic        r_convst, w_convst_nxt;
  logic        r_sck, w_sck_nxt;
  logic        r_sdi, w_sdi_nxt;
  logic [5:0]  r_word, w_word_nxt;
  logic [11:0] r_shift, w_shift_nxt;
  logic [2:0]  r_cur_ch, w_cur_ch_nxt;
  logic [2:0]  r_prev_ch, w_prev_ch_nxt;
  logic [11:0] r_data, w_data_nxt;
  logic [2:0]  r_data_ch, w_data_ch_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_prime, w_prime_nxt;
  logic        w_start;
  logic [5:0]  w_in_word;

  // LTC2308 config word: S/D, O/S, S1, S0, UNI, SLP (sleep never used)
  assign w_in_word = {cfg_sgl, cfg_ch[0], cfg_ch[2], cfg_ch[1], cfg_uni, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_t       <= 8'd0;
      r_hcnt    <= 8'd0;
      r_half    <= 5'd0;
      r_convst  <= 1'b0;
      r_sck     <= 1'b0;
      r_sdi     <= 1'b0;
      r_word    <= 6'd0;
      r_shift   <= 12'd0;
      r_cur_ch  <= 3'd0;
      r_prev_ch <= 3'd0;
      r_data    <= 12'd0;
      r_data_ch <= 3'd0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_prime   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_t       <= w_t_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_half    <= w_half_nxt;
      r_convst  <= w_convst_nxt;
      r_sck     <= w_sck_nxt;
      r_sdi     <= w_sdi_nxt;
      r_word    <= w_word_nxt;
      r_shift   <= w_shift_nxt;
      r_cur_ch  <= w_cur_ch_nxt;
      r_prev_ch <= w_prev_ch_nxt;
      r_data    <= w_data_nxt;
      r_data_ch <= w_data_ch_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_prime   <= w_prime_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_t_nxt       = r_t;
    w_hcnt_nxt    = r_hcnt;
    w_half_nxt    = r_half;
    w_convst_nxt  = r_convst;
    w_sck_nxt     = r_sck;
    w_sdi_nxt     = r_sdi;
    w_word_nxt    = r_word;
    w_shift_nxt   = r_shift;
    w_cur_ch_nxt  = r_cur_ch;
    w_prev_ch_nxt = r_prev_ch;
    w_data_nxt    = r_data;
    w_data_ch_nxt = r_data_ch;
    w_valid_nxt   = 1'b0;
    w_busy_nxt    = r_busy;
    w_prime_nxt   = r_prime;
    w_start       = 1'b0;

    if (r_state != S_IDLE) w_t_nxt = r_t + 8'd1;

    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_start     = 1'b1;
          w_prime_nxt = 1'b1;
        end
      end
      S_CONV: begin
        w_convst_nxt = (r_t + 8'd1) < T_CONVST;
        if (r_t == T_CONV_LAST) begin
          // this edge raises SCK for bit 0, so SDO bit 11 is captured now
          w_state_nxt = S_SHIFT;
          w_sck_nxt   = 1'b1;
          w_hcnt_nxt  = 8'd0;
          w_half_nxt  = 5'd0;
          w_shift_nxt = {r_shift[10:0], adc_sdo};
        end
      end
      S_SHIFT: begin
        if (r_hcnt == HALF_LAST) begin
          w_hcnt_nxt = 8'd0;
          if (r_half == 5'd23) begin
            w_state_nxt   = S_DONE;
            w_sck_nxt     = 1'b0;
            w_sdi_nxt     = 1'b0;
            w_prev_ch_nxt = r_cur_ch;
            w_prime_nxt   = 1'b0;
            if (!r_prime) begin
              w_data_nxt    = r_shift;
              w_data_ch_nxt = r_prev_ch;
              w_valid_nxt   = 1'b1;
            end
          end else begin
            w_half_nxt = r_half + 5'd1;
            w_sck_nxt  = ~r_sck;
            if (r_sck) begin
              w_sdi_nxt  = r_word[4];
              w_word_nxt = {r_word[4:0], 1'b0};
            end else begin
              w_shift_nxt = {r_shift[10:0], adc_sdo};
            end
          end
        end else begin
          w_hcnt_nxt = r_hcnt + 8'd1;
        end
      end
      S_DONE: begin
        if (r_t == T_CYC_LAST) begin
          if (en) begin
            w_start = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_t_nxt     = 8'd0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_start) begin
      w_state_nxt  = S_CONV;
      w_t_nxt      = 8'd0;
      w_convst_nxt = 1'b1;
      w_busy_nxt   = 1'b1;
      w_cur_ch_nxt = cfg_ch;
      w_word_nxt   = w_in_word;
      w_sdi_nxt    = w_in_word[5];
    end
  end

  assign adc_convst = r_convst;
  assign adc_sck    = r_sck;
  assign adc_sdi    = r_sdi;
  assign data       = r_data;
  assign data_ch    = r_data_ch;
  assign data_valid = r_valid;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ltc2308_ctrl.sv
// Bench for ltc2308_ctrl: pin-level timing monitor with an LTC2308 SDO model, a table of
// per-frame configs and hand-computed results, and directed sequences for en drop and reset.
module tb_ltc2308_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  cfg_ch;
  logic        cfg_sgl;
  logic        cfg_uni;
  logic        adc_convst;
  logic        adc_sck;
  logic        adc_sdi;
  logic        adc_sdo;
  logic [11:0] data;
  logic [2:0]  data_ch;
  logic        data_valid;
  logic        busy;
  logic [1:0]  dbg_state;

  ltc2308_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_ch     (cfg_ch),
    .cfg_sgl    (cfg_sgl),
    .cfg_uni    (cfg_uni),
    .adc_convst (adc_convst),
    .adc_sck    (adc_sck),
    .adc_sdi    (adc_sdi),
    .adc_sdo    (adc_sdo),
    .data       (data),
    .data_ch    (data_ch),
    .data_valid (data_valid),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: {data_ch, data}
  logic [14:0] exp_q[$];

  // monitor state
  int          cyc = 0;
  int          rise_cyc = 0;
  int          sck_rise_cyc = 0;
  int          sck_fall_cyc = 0;
  int          fall6_cyc = 0;
  int          sck_rises = 0;
  int          sck_falls = 0;
  int          dv_seen = 0;
  int          valid_cnt = 0;
  int          sdo_idx = 12;
  bit          cont = 0;
  logic        prev_convst = 1'b0;
  logic        prev_sck = 1'b0;
  logic        prev_dv = 1'b0;
  logic [11:0] sdi_cap = 12'd0;
  logic [11:0] sdo_cur = 12'd0;
  logic [11:0] sdo_next = 12'd0;
  logic [14:0] exp_e;

  // timing monitor + ADC SDO model (next bit presented after each SCK rise)
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_convst = 1'b0;
      prev_sck    = 1'b0;
      prev_dv     = 1'b0;
      cont        = 0;
      sck_rises   = 0;
      sck_falls   = 0;
      sdo_idx     = 12;
      adc_sdo     = 1'b0;
      exp_q.delete();
    end else begin
      if (!busy) cont = 0;
      if (adc_convst && !prev_convst) begin
        if (cont) begin
          check("t_cyc", 32'(cyc - rise_cyc), 32'd110);
          check("t_acq", 32'((cyc - fall6_cyc) >= 12), 32'd1);
        end
        rise_cyc  = cyc;
        cont      = 1;
        sck_rises = 0;
        sck_falls = 0;
        sdi_cap   = 12'd0;
        dv_seen   = 0;
        sdo_cur   = sdo_next;
        sdo_idx   = 0;
        adc_sdo   = sdo_cur[11];
      end
      if (!adc_convst && prev_convst)
        check("convst_high", 32'(cyc - rise_cyc), 32'd1);
      if (adc_sck && !prev_sck) begin
        if (sck_rises == 0) begin
          check("t_conv", 32'(cyc - rise_cyc), 32'd80);
        end else begin
          check("sck_low", 32'(cyc - sck_fall_cyc), 32'd1);
          check("sck_period", 32'(cyc - sck_rise_cyc), 32'd2);
        end
        sck_rise_cyc = cyc;
        sck_rises++;
        sdi_cap = {sdi_cap[10:0], adc_sdi};
        sdo_idx++;
        adc_sdo = (sdo_idx < 12) ? sdo_cur[11 - sdo_idx] : 1'b0;
      end
      if (!adc_sck && prev_sck) begin
        check("sck_high", 32'(cyc - sck_rise_cyc), 32'd1);
        sck_fall_cyc = cyc;
        sck_falls++;
        if (sck_falls == 6) fall6_cyc = cyc;
      end
      if (data_valid) begin
        dv_seen++;
        valid_cnt++;
        check("dv_pulse", 32'(prev_dv), 32'd0);
        check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          check("sb_result", 32'({data_ch, data}), 32'(exp_e));
        end
      end
      prev_convst = adc_convst;
      prev_sck    = adc_sck;
      prev_dv     = data_valid;
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_rise();
    int n;
    bit found;
    n = 0;
    found = 0;
    while (!found && n < 300) begin
      tick();
      n++;
      if (adc_convst) found = 1;
    end
    if (!found) check("rise_timeout", 32'(adc_convst), 32'd1);
  endtask

  typedef struct {
    logic [2:0]  ch;
    logic        sgl;
    logic        uni;
    logic [11:0] sdo;
    logic [5:0]  word;
    logic        valid;
    logic [11:0] data;
    logic [2:0]  dch;
  } vec_t;

  vec_t tab[10];
  int   v0;
  int   quiet_bad;

  initial begin
    //          ch    sgl   uni   sdo       sdi word    valid data     data_ch
    tab[0] = '{3'd3, 1'b1, 1'b1, 12'h123, 6'b110110, 1'b0, 12'h000, 3'd0};
    tab[1] = '{3'd3, 1'b1, 1'b1, 12'hA5C, 6'b110110, 1'b1, 12'hA5C, 3'd3};
    tab[2] = '{3'd5, 1'b1, 1'b1, 12'h3C7, 6'b111010, 1'b1, 12'h3C7, 3'd3};
    tab[3] = '{3'd6, 1'b0, 1'b0, 12'hFFF, 6'b001100, 1'b1, 12'hFFF, 3'd5};
    tab[4] = '{3'd0, 1'b1, 1'b0, 12'h000, 6'b100000, 1'b1, 12'h000, 3'd6};
    tab[5] = '{3'd7, 1'b0, 1'b1, 12'h801, 6'b011110, 1'b1, 12'h801, 3'd0};
    tab[6] = '{3'd2, 1'b1, 1'b1, 12'h7FE, 6'b100110, 1'b1, 12'h7FE, 3'd7};
    tab[7] = '{3'd4, 1'b0, 1'b0, 12'h555, 6'b001000, 1'b1, 12'h555, 3'd2};
    tab[8] = '{3'd1, 1'b1, 1'b0, 12'hAAA, 6'b110000, 1'b1, 12'hAAA, 3'd4};
    tab[9] = '{3'd3, 1'b1, 1'b1, 12'h0F0, 6'b110110, 1'b1, 12'h0F0, 3'd1};

    rst = 1'b1; en = 1'b0; cfg_ch = 3'd0; cfg_sgl = 1'b0; cfg_uni = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_pins", 32'({adc_convst, adc_sck, adc_sdi}), 32'd0);
    check("reset_data", 32'({data_ch, data}), 32'd0);
    check("reset_flags", 32'({data_valid, busy}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);

    // continuous run over the table: priming frame, then one result per frame
    cfg_ch = tab[0].ch; cfg_sgl = tab[0].sgl; cfg_uni = tab[0].uni;
    sdo_next = tab[0].sdo;
    en = 1'b1;
    v0 = valid_cnt;
    for (int i = 0; i < 10; i++) begin
      wait_rise();
      if (i < 9) begin
        cfg_ch = tab[i+1].ch; cfg_sgl = tab[i+1].sgl; cfg_uni = tab[i+1].uni;
        sdo_next = tab[i+1].sdo;
      end else begin
        cfg_ch = 3'd5; cfg_sgl = 1'b1; cfg_uni = 1'b1;
        sdo_next = 12'h9C3;
      end
      if (tab[i].valid) exp_q.push_back({tab[i].dch, tab[i].data});
      repeat (106) tick();
      check("sck_count", 32'(sck_rises), 32'd12);
      check("sdi_word", 32'(sdi_cap), 32'({tab[i].word, 6'b0}));
      check("dv_count", 32'(dv_seen), 32'(tab[i].valid));
      check("data", 32'(data), 32'(tab[i].data));
      check("data_ch", 32'(data_ch), 32'(tab[i].dch));
      check("busy_frame", 32'(busy), 32'd1);
    end
    check("valid_total", 32'(valid_cnt - v0), 32'd9);

    // en dropped at t=50: frame completes with its result, then idles
    wait_rise();
    exp_q.push_back({3'd3, 12'h9C3});
    repeat (50) tick();
    en = 1'b0;
    repeat (56) tick();
    check("stop_dv", 32'(dv_seen), 32'd1);
    check("stop_data", 32'({data_ch, data}), 32'({3'd3, 12'h9C3}));
    repeat (3) tick();
    check("stop_busy_t109", 32'(busy), 32'd1);
    tick();
    check("stop_busy_t110", 32'(busy), 32'd0);
    quiet_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (adc_convst || adc_sck || adc_sdi) quiet_bad++;
      tick();
    end
    check("idle_pins", 32'(quiet_bad), 32'd0);
    check("idle_state", 32'(dbg_state), 32'd0);

    // reset mid-SHIFT, then priming frame and resumed results
    cfg_ch = 3'd2; cfg_sgl = 1'b1; cfg_uni = 1'b1;
    sdo_next = 12'h111;
    en = 1'b1;
    wait_rise();
    sdo_next = 12'h333;
    repeat (90) tick();
    check("pre_rst_state", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    #1;
    check("rst_async_pins", 32'({adc_convst, adc_sck, adc_sdi}), 32'd0);
    check("rst_async_data", 32'({data_ch, data}), 32'd0);
    check("rst_async_flags", 32'({data_valid, busy, dbg_state}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    wait_rise();
    sdo_next = 12'h222;
    cfg_ch = 3'd6; cfg_sgl = 1'b0; cfg_uni = 1'b0;
    repeat (106) tick();
    check("prime_dv", 32'(dv_seen), 32'd0);
    check("prime_data", 32'({data_ch, data}), 32'd0);
    check("prime_sdi", 32'(sdi_cap), 32'({6'b100110, 6'b0}));
    wait_rise();
    en = 1'b0;
    exp_q.push_back({3'd2, 12'h222});
    repeat (106) tick();
    check("resume_dv", 32'(dv_seen), 32'd1);
    check("resume_data", 32'({data_ch, data}), 32'({3'd2, 12'h222}));
    check("resume_sdi", 32'(sdi_cap), 32'({6'b001100, 6'b0}));
    repeat (6) tick();
    check("final_busy", 32'(busy), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
